// File: rtl/arm_defs_pkg.sv
// Shared definitions for the ARM-style EXE stage: exe_cmd codes, control-word
// field positions and NZCV flag positions.
package arm_defs;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam int unsigned CW_W      = 9;
    localparam int unsigned CW_EXE_HI = 8;
    localparam int unsigned CW_EXE_LO = 5;
    localparam int unsigned CW_MR     = 4;
    localparam int unsigned CW_MW     = 3;
    localparam int unsigned CW_WB     = 2;
    localparam int unsigned CW_B      = 1;
    localparam int unsigned CW_S      = 0;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    function automatic logic cmd_valid(input logic [3:0] cmd);
        return (cmd >= EXE_MOV) && (cmd <= EXE_MVN);
    endfunction

    function automatic logic cmd_arith(input logic [3:0] cmd);
        return (cmd == EXE_ADD) || (cmd == EXE_ADC) || (cmd == EXE_SUB) || (cmd == EXE_SBC);
    endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational 32-bit ALU. C passes through unchanged and V reads 0 for
// non-arithmetic codes; the caller decides which flags to keep.
module exe_alu
    import arm_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [3:0]        i_exe_cmd,
    input  logic              i_c_in,
    output logic [DATA_W-1:0] o_res,
    output logic [3:0]        o_nzcv
);

    logic [DATA_W-1:0] w_op_b;
    logic              w_cin;
    logic              w_arith;
    logic [DATA_W:0]   w_sum;

    // Subtraction is a + ~b + cin, so C comes out as ARM's not-borrow.
    always_comb begin
        w_op_b  = i_b;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (i_exe_cmd)
            EXE_ADD: w_arith = 1'b1;
            EXE_ADC: begin w_arith = 1'b1; w_cin = i_c_in; end
            EXE_SUB: begin w_arith = 1'b1; w_op_b = ~i_b; w_cin = 1'b1; end
            EXE_SBC: begin w_arith = 1'b1; w_op_b = ~i_b; w_cin = i_c_in; end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, i_a} + {1'b0, w_op_b} + {{DATA_W{1'b0}}, w_cin};

    always_comb begin
        o_res = '0;
        case (i_exe_cmd)
            EXE_MOV: o_res = i_b;
            EXE_MVN: o_res = ~i_b;
            EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: o_res = w_sum[DATA_W-1:0];
            EXE_AND: o_res = i_a & i_b;
            EXE_ORR: o_res = i_a | i_b;
            EXE_EOR: o_res = i_a ^ i_b;
            default: o_res = '0;
        endcase
    end

    always_comb begin
        o_nzcv         = '0;
        o_nzcv[FLAG_N] = o_res[DATA_W-1];
        o_nzcv[FLAG_Z] = (o_res == '0);
        o_nzcv[FLAG_C] = w_arith ? w_sum[DATA_W] : i_c_in;
        o_nzcv[FLAG_V] = w_arith && (i_a[DATA_W-1] == w_op_b[DATA_W-1])
                         && (w_sum[DATA_W-1] != i_a[DATA_W-1]);
    end

endmodule

// File: rtl/exe_stage.sv
// EXE stage: ID/EXE register, ALU, NZCV status register, branch resolution and
// the EXE/MEM output register.
module exe_stage
    import arm_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic [CW_W-1:0]   control_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [23:0]       imm24,
    input  logic [3:0]        dest_in,
    output logic [3:0]        status_out,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] st_val,
    output logic [3:0]        dest_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              wb_en_out
);

    logic [CW_W-1:0]   r_ctrl;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_rn;
    logic [DATA_W-1:0] r_val2;
    logic [DATA_W-1:0] r_rm;
    logic [23:0]       r_imm24;
    logic [3:0]        r_dest;
    logic [3:0]        r_status;
    logic [DATA_W-1:0] r_alu_res;
    logic [DATA_W-1:0] r_st_val;
    logic [3:0]        r_dest_out;
    logic              r_mr;
    logic              r_mw;
    logic              r_wb;

    logic [3:0]        w_cmd;
    logic [DATA_W-1:0] w_res;
    logic [3:0]        w_nzcv;
    logic [3:0]        w_flags;
    logic              w_status_we;

    assign w_cmd = r_ctrl[CW_EXE_HI:CW_EXE_LO];

    // Flush only has to zero the control word; data fields are don't-care.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl  <= '0;
            r_pc    <= '0;
            r_rn    <= '0;
            r_val2  <= '0;
            r_rm    <= '0;
            r_imm24 <= '0;
            r_dest  <= '0;
        end else if (flush || !freeze) begin
            r_ctrl  <= flush ? '0 : control_in;
            r_pc    <= pc_in;
            r_rn    <= val_rn;
            r_val2  <= val2;
            r_rm    <= val_rm;
            r_imm24 <= imm24;
            r_dest  <= dest_in;
        end
    end

    exe_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a       (r_rn),
        .i_b       (r_val2),
        .i_exe_cmd (w_cmd),
        .i_c_in    (r_status[FLAG_C]),
        .o_res     (w_res),
        .o_nzcv    (w_nzcv)
    );

    assign w_flags = {w_nzcv[FLAG_N], w_nzcv[FLAG_Z],
                      cmd_arith(w_cmd) ? w_nzcv[FLAG_C] : r_status[FLAG_C],
                      cmd_arith(w_cmd) ? w_nzcv[FLAG_V] : r_status[FLAG_V]};

    // Loads and stores use the ALU for address math and never touch flags.
    assign w_status_we = r_ctrl[CW_S] && !r_ctrl[CW_MR] && !r_ctrl[CW_MW] && cmd_valid(w_cmd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= '0;
        end else if (w_status_we) begin
            r_status <= w_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_res  <= '0;
            r_st_val   <= '0;
            r_dest_out <= '0;
            r_mr       <= 1'b0;
            r_mw       <= 1'b0;
            r_wb       <= 1'b0;
        end else begin
            r_alu_res  <= w_res;
            r_st_val   <= r_rm;
            r_dest_out <= r_dest;
            r_mr       <= r_ctrl[CW_MR];
            r_mw       <= r_ctrl[CW_MW];
            r_wb       <= r_ctrl[CW_WB];
        end
    end

    assign status_out   = r_status;
    assign branch_taken = r_ctrl[CW_B];
    assign branch_addr  = r_pc + {{(DATA_W-26){r_imm24[23]}}, r_imm24, 2'b00};
    assign alu_res      = r_alu_res;
    assign st_val       = r_st_val;
    assign dest_out     = r_dest_out;
    assign mem_r_en_out = r_mr;
    assign mem_w_en_out = r_mw;
    assign wb_en_out    = r_wb;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed vector table, hand-written
// multi-cycle sequences and a randomized run against an arithmetic model.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic [8:0]  control_in = '0;
    logic [31:0] pc_in = '0;
    logic [31:0] val_rn = '0;
    logic [31:0] val2 = '0;
    logic [31:0] val_rm = '0;
    logic [23:0] imm24 = '0;
    logic [3:0]  dest_in = '0;
    logic [3:0]  status_out;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [3:0]  dest_out;
    logic        mem_r_en_out;
    logic        mem_w_en_out;
    logic        wb_en_out;

    int n_checks = 0;
    int n_fail   = 0;

    exe_stage #(
        .DATA_W (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .flush        (flush),
        .control_in   (control_in),
        .pc_in        (pc_in),
        .val_rn       (val_rn),
        .val2         (val2),
        .val_rm       (val_rm),
        .imm24        (imm24),
        .dest_in      (dest_in),
        .status_out   (status_out),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .alu_res      (alu_res),
        .st_val       (st_val),
        .dest_out     (dest_out),
        .mem_r_en_out (mem_r_en_out),
        .mem_w_en_out (mem_w_en_out),
        .wb_en_out    (wb_en_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] cw(input logic [3:0] cmd, input bit mr, input bit mw,
                                      input bit wb, input bit b, input bit s);
        return {cmd, mr, mw, wb, b, s};
    endfunction

    // Reference ALU from plain integer arithmetic; flags in NZCV order.
    function automatic void ref_exec(input logic [3:0] cmd, input logic [31:0] a,
                                     input logic [31:0] b, input logic [3:0] f_in,
                                     output logic [31:0] res, output logic [3:0] f_out,
                                     output bit valid);
        longint ua, ub, sa, sb, full, sfull;
        longint lim;
        bit     cin, c, v, arith;
        lim   = 64'sd2147483647;
        ua    = longint'({32'd0, a});
        ub    = longint'({32'd0, b});
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        cin   = f_in[1];
        c     = f_in[1];
        v     = f_in[0];
        arith = 1'b0;
        valid = 1'b1;
        full  = 0;
        sfull = 0;
        res   = '0;
        case (cmd)
            4'd1: res = b;
            4'd9: res = ~b;
            4'd6: res = a & b;
            4'd7: res = a | b;
            4'd8: res = a ^ b;
            4'd2: begin full = ua + ub; sfull = sa + sb; arith = 1'b1; c = full > 64'hFFFF_FFFF; end
            4'd3: begin
                full = ua + ub + longint'(cin); sfull = sa + sb + longint'(cin);
                arith = 1'b1; c = full > 64'hFFFF_FFFF;
            end
            4'd4: begin full = ua - ub; sfull = sa - sb; arith = 1'b1; c = ua >= ub; end
            4'd5: begin
                full = ua - ub - longint'(!cin); sfull = sa - sb - longint'(!cin);
                arith = 1'b1; c = ua >= ub + longint'(!cin);
            end
            default: valid = 1'b0;
        endcase
        if (arith) begin
            res = full[31:0];
            v   = (sfull > lim) || (sfull < -lim - 1);
        end
        f_out = {res[31], res == 32'd0, c, v};
    endfunction

    typedef struct {
        logic [8:0]  ctrl;
        logic [31:0] rn;
        logic [31:0] v2;
        logic [31:0] exp_res;
        logic [3:0]  exp_nzcv;
    } vec_t;

    vec_t vecs[12];

    // Randomized-phase model state
    logic [8:0]  m_ctrl;
    logic [31:0] m_pc, m_rn, m_val2, m_rm;
    logic [23:0] m_imm;
    logic [3:0]  m_dest, m_status;
    bit          m_known;
    logic [31:0] e_res, e_st;
    logic [3:0]  e_dest;
    logic [2:0]  e_en;
    bit          e_known;

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r_res;
        logic [3:0]  r_f;
        bit          r_valid;
        logic [31:0] exp_addr;

        vecs[0]  = '{cw(4'b0010, 0, 0, 1, 0, 1), 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001};
        vecs[1]  = '{cw(4'b0100, 0, 0, 1, 0, 1), 32'd5, 32'd5, 32'd0, 4'b0110};
        vecs[2]  = '{cw(4'b0101, 0, 0, 1, 0, 1), 32'd10, 32'd3, 32'd7, 4'b0010};
        vecs[3]  = '{cw(4'b0100, 0, 0, 1, 0, 1), 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0011};
        vecs[4]  = '{cw(4'b0110, 0, 0, 1, 0, 1), 32'h0000_00F0, 32'h0000_000F, 32'd0, 4'b0111};
        vecs[5]  = '{cw(4'b0010, 1, 0, 1, 0, 1), 32'h0000_1000, 32'h0000_0020, 32'h1020, 4'b0111};
        vecs[6]  = '{cw(4'b1001, 0, 0, 1, 0, 1), 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 4'b1011};
        vecs[7]  = '{cw(4'b0011, 0, 0, 1, 0, 1), 32'hFFFF_FFFF, 32'd0, 32'd0, 4'b0110};
        vecs[8]  = '{cw(4'b1000, 0, 0, 1, 0, 0), 32'h0000_00FF, 32'h0000_000F, 32'hF0, 4'b0110};
        vecs[9]  = '{cw(4'b1111, 0, 0, 1, 0, 1), 32'h5555_5555, 32'h1, 32'd0, 4'b0110};
        vecs[10] = '{cw(4'b0111, 0, 0, 1, 0, 1), 32'h8000_0000, 32'd1, 32'h8000_0001, 4'b1010};
        vecs[11] = '{cw(4'b0001, 0, 1, 0, 0, 1), 32'hDEAD_BEEF, 32'd0, 32'd0, 4'b1010};

        // Reset state, asynchronous before any clock edge
        #1;
        check("reset_alu_res", alu_res, 32'd0);
        check("reset_status", status_out, 4'd0);
        check("reset_enables", {29'd0, mem_r_en_out, mem_w_en_out, wb_en_out}, 32'd0);
        check("reset_branch", branch_taken, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            control_in = vecs[i].ctrl;
            val_rn     = vecs[i].rn;
            val2       = vecs[i].v2;
            val_rm     = 32'hA000_0000 + i;
            dest_in    = 4'(i);
            step();
            control_in = '0;
            step();
            check($sformatf("vec%0d_alu_res", i), alu_res, vecs[i].exp_res);
            check($sformatf("vec%0d_status", i), status_out, vecs[i].exp_nzcv);
            check($sformatf("vec%0d_enables", i), {mem_r_en_out, mem_w_en_out, wb_en_out},
                  {vecs[i].ctrl[4], vecs[i].ctrl[3], vecs[i].ctrl[2]});
            check($sformatf("vec%0d_st_val", i), st_val, 32'hA000_0000 + i);
            check($sformatf("vec%0d_dest", i), dest_out, i);
        end

        // Branch, held under freeze, cleared by flush
        control_in = cw(4'b0000, 0, 0, 0, 1, 0);
        pc_in      = 32'h100;
        imm24      = 24'hFFFFFE;
        step();
        check("branch_taken", branch_taken, 1'b1);
        check("branch_addr", branch_addr, 32'h0000_00F8);
        control_in = '0;
        freeze     = 1'b1;
        step();
        check("branch_taken_frozen", branch_taken, 1'b1);
        freeze = 1'b0;
        flush  = 1'b1;
        step();
        flush = 1'b0;
        check("branch_flushed", branch_taken, 1'b0);

        // Freeze holds MOV for three cycles
        control_in = cw(4'b0001, 0, 0, 1, 0, 0);
        val2       = 32'h55;
        step();
        freeze = 1'b1;
        val2   = 32'hAA;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("freeze_hold%0d", i), alu_res, 32'h55);
            check($sformatf("freeze_wb%0d", i), wb_en_out, 1'b1);
        end
        // Flush beats freeze
        control_in = cw(4'b0010, 1, 1, 1, 0, 0);
        flush      = 1'b1;
        step();
        flush      = 1'b0;
        freeze     = 1'b0;
        control_in = '0;
        step();
        check("flush_over_freeze_en", {mem_r_en_out, mem_w_en_out, wb_en_out}, 3'b000);
        check("flush_over_freeze_res", alu_res, 32'd0);

        // Async reset mid-stream during ADC
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_pulse_status", status_out, 4'd0);
        @(negedge clk);
        rst        = 1'b0;
        control_in = cw(4'b0011, 0, 0, 1, 1, 1);
        val_rn     = 32'hFFFF_FFF0;
        val2       = 32'h20;
        step();
        step();
        check("adc_before_rst_res", alu_res, 32'h10);
        check("adc_before_rst_status", status_out, 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_res", alu_res, 32'd0);
        check("async_rst_status", status_out, 4'd0);
        check("async_rst_wb", wb_en_out, 1'b0);
        check("async_rst_branch", branch_taken, 1'b0);
        @(negedge clk);
        rst        = 1'b0;
        control_in = '0;

        // Randomized run against the model
        m_ctrl = '0; m_pc = '0; m_rn = '0; m_val2 = '0; m_rm = '0; m_imm = '0; m_dest = '0;
        m_status = '0; m_known = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            freeze     = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            control_in = {4'($urandom_range(0, 15)), 1'($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom),
                          1'($urandom_range(0, 3) != 0)};
            pc_in      = $urandom;
            val_rn     = pick_operand();
            val2       = pick_operand();
            val_rm     = $urandom;
            imm24      = 24'($urandom);
            dest_in    = 4'($urandom);

            ref_exec(m_ctrl[8:5], m_rn, m_val2, m_status, r_res, r_f, r_valid);
            e_res   = r_res;
            e_st    = m_rm;
            e_dest  = m_dest;
            e_en    = {m_ctrl[4], m_ctrl[3], m_ctrl[2]};
            e_known = m_known;
            if (m_ctrl[0] && !m_ctrl[4] && !m_ctrl[3] && r_valid) m_status = r_f;
            if (flush) begin
                m_ctrl = '0; m_known = 1'b0;
            end else if (!freeze) begin
                m_ctrl = control_in; m_pc = pc_in; m_rn = val_rn; m_val2 = val2;
                m_rm = val_rm; m_imm = imm24; m_dest = dest_in; m_known = 1'b1;
            end
            step();
            check("rnd_alu_res", alu_res, e_res);
            check("rnd_status", status_out, m_status);
            check("rnd_enables", {mem_r_en_out, mem_w_en_out, wb_en_out}, e_en);
            check("rnd_branch_taken", branch_taken, m_ctrl[1]);
            if (m_ctrl[1]) begin
                exp_addr = m_pc + 32'(longint'($signed(m_imm)) * 4);
                check("rnd_branch_addr", branch_addr, exp_addr);
            end
            if (e_known) begin
                check("rnd_st_val", st_val, e_st);
                check("rnd_dest", dest_out, e_dest);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
